// File: rtl/ex_stage_pkg.sv
// Shared opcode/result-class encodings, divider states and stall levels for
// the execute stage and its iterative divider.
package ex_stage_pkg;

    localparam int DIV_CYCLES = 32;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_JALR_OP = 8'b0000_1001;
    localparam logic [7:0] EXE_JAL_OP  = 8'b0101_0000;

    localparam logic [2:0] EXE_RES_NOP         = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH       = 3'b100;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_BUSY   = 2'b10,
        DIV_DONE   = 2'b11
    } div_state_e;

    localparam logic StallEnable  = 1'b1;
    localparam logic StallDisable = 1'b0;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operation bundle in, write-back/forwarding bundle plus HI/LO and stall out.
interface ex_stage_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] rdata1_i;
    logic [31:0] rdata2_i;
    logic [4:0]  waddr_reg_i;
    logic        we_reg_i;
    logic [31:0] return_addr_i;
    logic        in_delayslot_i;
    logic        flush_i;

    logic [31:0] wdata_o;
    logic [4:0]  waddr_reg_o;
    logic        we_reg_o;
    logic        in_delayslot_o;
    logic        stall_req_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output aluop_i, alusel_i, rdata1_i, rdata2_i, waddr_reg_i, we_reg_i,
               return_addr_i, in_delayslot_i, flush_i,
        input  wdata_o, waddr_reg_o, we_reg_o, in_delayslot_o, stall_req_o, hi_o, lo_o
    );

    modport slave (
        input  aluop_i, alusel_i, rdata1_i, rdata2_i, waddr_reg_i, we_reg_i,
               return_addr_i, in_delayslot_i, flush_i,
        output wdata_o, waddr_reg_o, we_reg_o, in_delayslot_o, stall_req_o, hi_o, lo_o
    );
endinterface

// File: rtl/ex_stage_div_iter.sv
// Restoring divider, one quotient bit per cycle over DIV_CYCLES cycles.
// result_o = {remainder, quotient}, valid while ready_o is high.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        ready_o,
    output logic [63:0] result_o
);

    localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] work_q, work_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic [31:0] mag1, mag2, quo_s, rem_s;
    logic [32:0] trial;

    assign mag1  = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    assign mag2  = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    // Shifted partial remainder keeps its carry-out so divisors >= 2^31 still work.
    assign trial = work_q[63:31] - {1'b0, dvsr_q};
    assign quo_s = neg_quo_q ? -work_q[31:0]  : work_q[31:0];
    assign rem_s = neg_rem_q ? -work_q[63:32] : work_q[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_o   = 1'b0;
        result_o  = '0;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        work_d    = {32'b0, mag1};
                        dvsr_d    = mag2;
                        neg_quo_d = signed_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_d = signed_i && opdata1_i[31];
                        cnt_d     = '0;
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (trial[32]) work_d = {work_q[62:0], 1'b0};
                else           work_d = {trial[31:0], work_q[30:0], 1'b1};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                ready_o  = 1'b1;
                result_o = {rem_s, quo_s};
                state_d  = DIV_IDLE;
            end
            DIV_BYZERO: begin
                ready_o  = 1'b1;
                state_d  = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        // An annulled division neither completes nor touches HI/LO.
        if (annul_i) begin
            state_d = DIV_IDLE;
            ready_o = 1'b0;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU result select, HI/LO registers and the iterative divider
// whose run holds the front of the pipeline via stall_req_o.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_stage_if.slave bus
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        is_div, is_mt, div_ready;
    logic [63:0] div_result;
    logic [31:0] logic_res, shift_res, move_res, wdata;
    logic        we, stall;

    assign is_div = is_div_op(bus.aluop_i);
    assign is_mt  = (bus.aluop_i == EXE_MTHI_OP) || (bus.aluop_i == EXE_MTLO_OP);

    // done_q keeps the still-held divide from restarting after it completes.
    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (is_div && !done_q),
        .signed_i  (bus.aluop_i == EXE_DIV_OP),
        .opdata1_i (bus.rdata1_i),
        .opdata2_i (bus.rdata2_i),
        .annul_i   (bus.flush_i),
        .ready_o   (div_ready),
        .result_o  (div_result)
    );

    always_comb begin
        logic_res = '0;
        shift_res = '0;
        move_res  = '0;
        unique case (bus.aluop_i)
            EXE_AND_OP:  logic_res = bus.rdata1_i & bus.rdata2_i;
            EXE_OR_OP:   logic_res = bus.rdata1_i | bus.rdata2_i;
            EXE_XOR_OP:  logic_res = bus.rdata1_i ^ bus.rdata2_i;
            EXE_NOR_OP:  logic_res = ~(bus.rdata1_i | bus.rdata2_i);
            EXE_SLL_OP:  shift_res = bus.rdata2_i << bus.rdata1_i[4:0];
            EXE_SRL_OP:  shift_res = bus.rdata2_i >> bus.rdata1_i[4:0];
            EXE_SRA_OP:  shift_res = $signed(bus.rdata2_i) >>> bus.rdata1_i[4:0];
            EXE_MFHI_OP: move_res  = hi_q;
            EXE_MFLO_OP: move_res  = lo_q;
            default: ;
        endcase

        wdata = '0;
        unique case (bus.alusel_i)
            EXE_RES_LOGIC:       wdata = logic_res;
            EXE_RES_SHIFT:       wdata = shift_res;
            EXE_RES_MOVE:        wdata = move_res;
            EXE_RES_JUMP_BRANCH: wdata = bus.return_addr_i;
            default: ;
        endcase

        we    = bus.we_reg_i && !bus.flush_i && !is_div && !is_mt;
        stall = (is_div && !done_q && !div_ready && !bus.flush_i) ? StallEnable : StallDisable;

        hi_d = hi_q;
        lo_d = lo_q;
        if (div_ready) begin
            {hi_d, lo_d} = div_result;
        end else if (!bus.flush_i) begin
            if (bus.aluop_i == EXE_MTHI_OP) hi_d = bus.rdata1_i;
            if (bus.aluop_i == EXE_MTLO_OP) lo_d = bus.rdata1_i;
        end

        done_d = done_q;
        if (div_ready)   done_d = 1'b1;
        else if (!is_div) done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign bus.wdata_o        = rst ? '0   : wdata;
    assign bus.waddr_reg_o    = rst ? '0   : bus.waddr_reg_i;
    assign bus.we_reg_o       = rst ? 1'b0 : we;
    assign bus.in_delayslot_o = rst ? 1'b0 : bus.in_delayslot_i;
    assign bus.stall_req_o    = rst ? 1'b0 : stall;
    assign bus.hi_o           = rst ? '0   : hi_q;
    assign bus.lo_o           = rst ? '0   : lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations queued at drive time, compared at negedge.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int S_WDATA = 0, S_WADDR = 1, S_WE = 2, S_STALL = 3,
                   S_HI = 4, S_LO = 5, S_DSLOT = 6, S_MEAS = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } alu_vec_t;

    logic clk, rst;
    int   n_chk, n_fail;
    exp_t sb_q[$];

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain(input logic [31:0] meas);
        exp_t e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                S_WDATA: obs = bus.wdata_o;
                S_WADDR: obs = 32'(bus.waddr_reg_o);
                S_WE:    obs = 32'(bus.we_reg_o);
                S_STALL: obs = 32'(bus.stall_req_o);
                S_HI:    obs = bus.hi_o;
                S_LO:    obs = bus.lo_o;
                S_DSLOT: obs = 32'(bus.in_delayslot_o);
                default: obs = meas;
            endcase
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.rdata1_i = a;
        bus.rdata2_i = b;
    endtask

    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0]  s;
        logic [31:0] fill;
        s    = a[4:0];
        fill = b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        case (op)
            EXE_AND_OP: return a & b;
            EXE_OR_OP:  return a | b;
            EXE_XOR_OP: return a ^ b;
            EXE_NOR_OP: return ~(a | b);
            EXE_SLL_OP: return b << s;
            EXE_SRL_OP: return b >> s;
            EXE_SRA_OP: return (b >> s) | fill;
            default:    return 32'h0;
        endcase
    endfunction

    // {hi, lo} reference using 64-bit arithmetic so INT_MIN / -1 cannot overflow.
    function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b);
        logic [63:0] exp_hl;
        int n, idle_stalls;
        exp_hl = div_model(sgn, a, b);
        cyc();
        set_op(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_ARITH, a, b);
        bus.we_reg_i    = 1'b1;
        bus.waddr_reg_i = 5'd3;
        @(negedge clk);
        push({tag, "_we"}, S_WE, 32'd0);
        drain(0);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (!bus.stall_req_o) break;
            n++;
            @(negedge clk);
        end
        push({tag, "_stall_cycles"}, S_MEAS, (b == 0) ? 32'd1 : 32'd33);
        drain(32'(n));
        cyc();
        @(negedge clk);
        push({tag, "_hi"}, S_HI, exp_hl[63:32]);
        push({tag, "_lo"}, S_LO, exp_hl[31:0]);
        drain(0);
        idle_stalls = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.stall_req_o) idle_stalls++;
        end
        push({tag, "_no_restart"}, S_MEAS, 32'd0);
        push({tag, "_hi_held"}, S_HI, exp_hl[63:32]);
        drain(32'(idle_stalls));
        cyc();
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
    endtask

    initial begin
        alu_vec_t vecs[$];
        int n;
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        set_op(EXE_DIVU_OP, EXE_RES_ARITH, 32'd100, 32'd7);
        bus.waddr_reg_i    = 5'd9;
        bus.we_reg_i       = 1'b1;
        bus.return_addr_i  = 32'h0;
        bus.in_delayslot_i = 1'b1;
        bus.flush_i        = 1'b0;

        cyc();
        @(negedge clk);
        push("rst_wdata", S_WDATA, 32'h0);
        push("rst_waddr", S_WADDR, 32'h0);
        push("rst_we", S_WE, 32'h0);
        push("rst_stall", S_STALL, 32'h0);
        push("rst_dslot", S_DSLOT, 32'h0);
        push("rst_hi", S_HI, 32'h0);
        push("rst_lo", S_LO, 32'h0);
        drain(0);

        cyc();
        rst = 1'b0;
        bus.in_delayslot_i = 1'b0;
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_FFFF);
        @(negedge clk);
        push("or_wdata", S_WDATA, 32'h1234_FFFF);
        push("or_we", S_WE, 32'd1);
        push("or_stall", S_STALL, 32'd0);
        drain(0);

        vecs.push_back('{EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000});
        vecs.push_back('{EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000});
        vecs.push_back('{EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'h0000_0003});
        vecs.push_back('{EXE_SRA_OP, EXE_RES_SHIFT, 32'd36, 32'h7000_0000});
        vecs.push_back('{EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF});
        vecs.push_back('{EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000});
        vecs.push_back('{EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{EXE_XOR_OP, EXE_RES_LOGIC, $urandom, $urandom});
        foreach (vecs[i]) begin
            cyc();
            set_op(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b);
            @(negedge clk);
            push($sformatf("alu%0d_op%h", i, vecs[i].op), S_WDATA,
                 alu_model(vecs[i].op, vecs[i].a, vecs[i].b));
            drain(0);
        end

        cyc();
        set_op(EXE_JALR_OP, EXE_RES_JUMP_BRANCH, 32'h5555_0000, 32'h0);
        bus.return_addr_i  = 32'h0000_0010;
        bus.waddr_reg_i    = 5'd31;
        bus.in_delayslot_i = 1'b1;
        @(negedge clk);
        push("jalr_wdata", S_WDATA, 32'h10);
        push("jalr_waddr", S_WADDR, 32'd31);
        push("jalr_we", S_WE, 32'd1);
        push("jalr_dslot", S_DSLOT, 32'd1);
        drain(0);
        bus.in_delayslot_i = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        cyc();
        set_op(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0);
        @(negedge clk);
        push("mflo_wdata", S_WDATA, 32'd14);
        drain(0);
        cyc();
        set_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0);
        @(negedge clk);
        push("mfhi_wdata", S_WDATA, 32'd2);
        drain(0);

        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_div("div_by0", 1'b1, 32'h1234_5678, 32'h0);

        // Flush mid-divide: HI/LO from the MTHI/MTLO must survive.
        cyc();
        set_op(EXE_MTHI_OP, EXE_RES_MOVE, 32'h0000_AAAA, 32'h0);
        bus.we_reg_i = 1'b1;
        @(negedge clk);
        push("mthi_we", S_WE, 32'd0);
        push("mthi_wdata", S_WDATA, 32'd0);
        drain(0);
        cyc();
        set_op(EXE_MTLO_OP, EXE_RES_MOVE, 32'h0000_5555, 32'h0);
        @(negedge clk);
        push("mthi_hi", S_HI, 32'h0000_AAAA);
        drain(0);
        cyc();
        set_op(EXE_DIVU_OP, EXE_RES_ARITH, 32'd100, 32'd7);
        @(negedge clk);
        push("fl_issue_stall", S_STALL, 32'd1);
        push("mtlo_lo", S_LO, 32'h0000_5555);
        drain(0);
        repeat (10) cyc();
        bus.flush_i = 1'b1;
        @(negedge clk);
        push("fl_pulse_stall", S_STALL, 32'd0);
        drain(0);
        cyc();
        bus.flush_i = 1'b0;
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        @(negedge clk);
        push("fl_after_stall", S_STALL, 32'd0);
        push("fl_hi", S_HI, 32'h0000_AAAA);
        push("fl_lo", S_LO, 32'h0000_5555);
        drain(0);
        repeat (40) cyc();
        @(negedge clk);
        push("fl_hi_late", S_HI, 32'h0000_AAAA);
        drain(0);

        // Reset mid-divide: HI/LO cleared and the divider back in IDLE.
        cyc();
        set_op(EXE_MTHI_OP, EXE_RES_MOVE, 32'h0000_AAAA, 32'h0);
        cyc();
        set_op(EXE_DIVU_OP, EXE_RES_ARITH, 32'd100, 32'd7);
        repeat (10) cyc();
        rst = 1'b1;
        @(negedge clk);
        push("rs_pulse_stall", S_STALL, 32'd0);
        drain(0);
        cyc();
        rst = 1'b0;
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0);
        @(negedge clk);
        push("rs_hi", S_HI, 32'h0);
        push("rs_lo", S_LO, 32'h0);
        push("rs_stall", S_STALL, 32'd0);
        drain(0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.stall_req_o) n++;
        end
        push("rs_idle_quiet", S_MEAS, 32'd0);
        drain(32'(n));
        run_div("rs_fresh_divu", 1'b0, 32'd100, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
